// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU codes, operation classes, function/opcode constants, sequencer states
package alu_ctrl_pkg;

    typedef logic [3:0] alu_code_t;

    localparam alu_code_t ALU_AND    = 4'b0000;
    localparam alu_code_t ALU_OR     = 4'b0001;
    localparam alu_code_t ALU_ADD    = 4'b0010;
    localparam alu_code_t ALU_XOR    = 4'b0011;
    localparam alu_code_t ALU_NOR    = 4'b0100;
    localparam alu_code_t ALU_SLL    = 4'b0101;
    localparam alu_code_t ALU_SUB    = 4'b0110;
    localparam alu_code_t ALU_SLT    = 4'b0111;
    localparam alu_code_t ALU_SRL    = 4'b1000;
    localparam alu_code_t ALU_SRA    = 4'b1001;
    localparam alu_code_t ALU_SLTU   = 4'b1010;
    localparam alu_code_t ALU_LUI    = 4'b1011;
    localparam alu_code_t ALU_MULDIV = 4'b1100;

    typedef enum logic [2:0] {
        OP_MEM    = 3'b000,
        OP_BRANCH = 3'b001,
        OP_RTYPE  = 3'b010,
        OP_ITYPE  = 3'b011,
        OP_LUI    = 3'b100
    } alu_op_e;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_BUSY = 1'b1
    } seq_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - mult/div occupancy tracker: IDLE/BUSY FSM with a down-counter
module muldiv_seq #(
    parameter int MULDIV_LAT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic flush,
    output logic busy
);
    import alu_ctrl_pkg::*;

    localparam int CNT_W = $clog2(MULDIV_LAT + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds remaining busy cycles after the current one; stalls do not pause it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = SEQ_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (start) begin
                        state_d = SEQ_BUSY;
                        cnt_d   = CNT_W'(MULDIV_LAT - 1);
                    end
                end
                SEQ_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = SEQ_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = SEQ_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q == SEQ_BUSY);

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered ALU-control decode stage; ALU_CTRL_MULDIV_EN enables mult/div sequencer
module alu_ctrl_stage #(
    parameter int NB_ALU_CONTROL = 4,
    parameter int NB_ALU_OP      = 3,
    parameter int NB_FUNCION     = 6,
    parameter int NB_OPCODE      = 6,
    parameter int MULDIV_LAT     = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [NB_ALU_OP-1:0]      i_alu_op,
    input  logic [NB_FUNCION-1:0]     i_inst_funcion,
    input  logic [NB_OPCODE-1:0]      i_opcode,
    output logic                      o_ready,
    output logic                      o_valid,
    output logic [NB_ALU_CONTROL-1:0] o_alu_code,
    output logic                      o_shift_imm,
    output logic                      o_shift_var,
    output logic                      o_illegal,
    output logic                      o_busy
);
    import alu_ctrl_pkg::*;

    alu_code_t dec_code;
    logic      dec_imm;
    logic      dec_var;
    logic      dec_ill;
    logic      accept;

    always_comb begin
        dec_code = ALU_ADD;
        dec_imm  = 1'b0;
        dec_var  = 1'b0;
        dec_ill  = 1'b0;
        case (i_alu_op)
            OP_MEM:    dec_code = ALU_ADD;
            OP_BRANCH: dec_code = ALU_SUB;
            OP_LUI:    dec_code = ALU_LUI;
            OP_RTYPE: begin
                case (i_inst_funcion)
                    FN_ADD, FN_ADDU: dec_code = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_code = ALU_SUB;
                    FN_AND:          dec_code = ALU_AND;
                    FN_OR:           dec_code = ALU_OR;
                    FN_XOR:          dec_code = ALU_XOR;
                    FN_NOR:          dec_code = ALU_NOR;
                    FN_SLT:          dec_code = ALU_SLT;
                    FN_SLTU:         dec_code = ALU_SLTU;
                    FN_SLL:  begin dec_code = ALU_SLL; dec_imm = 1'b1; end
                    FN_SRL:  begin dec_code = ALU_SRL; dec_imm = 1'b1; end
                    FN_SRA:  begin dec_code = ALU_SRA; dec_imm = 1'b1; end
                    FN_SLLV: begin dec_code = ALU_SLL; dec_var = 1'b1; end
                    FN_SRLV: begin dec_code = ALU_SRL; dec_var = 1'b1; end
                    FN_SRAV: begin dec_code = ALU_SRA; dec_var = 1'b1; end
`ifdef ALU_CTRL_MULDIV_EN
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: dec_code = ALU_MULDIV;
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                case (i_opcode)
                    OPC_ADDI, OPC_ADDIU: dec_code = ALU_ADD;
                    OPC_SLTI:            dec_code = ALU_SLT;
                    OPC_SLTIU:           dec_code = ALU_SLTU;
                    OPC_ANDI:            dec_code = ALU_AND;
                    OPC_ORI:             dec_code = ALU_OR;
                    OPC_XORI:            dec_code = ALU_XOR;
                    OPC_LUI:             dec_code = ALU_LUI;
                    default:             dec_ill  = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign accept = i_valid & o_ready & ~i_stall & ~i_flush;

    // A flush looks like reset to the output register; a plain idle cycle only drops o_valid.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            o_valid     <= 1'b0;
            o_alu_code  <= ALU_ADD;
            o_shift_imm <= 1'b0;
            o_shift_var <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (i_stall) begin
            o_valid     <= o_valid;
        end else if (accept) begin
            o_valid     <= 1'b1;
            o_alu_code  <= dec_code;
            o_shift_imm <= dec_imm;
            o_shift_var <= dec_var;
            o_illegal   <= dec_ill;
        end else begin
            o_valid     <= 1'b0;
        end
    end

`ifdef ALU_CTRL_MULDIV_EN
    muldiv_seq #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_muldiv_seq (
        .clock (i_clock),
        .reset (i_reset),
        .start (accept && (dec_code == ALU_MULDIV)),
        .flush (i_flush),
        .busy  (o_busy)
    );
`else
    assign o_busy = 1'b0;
`endif

    assign o_ready = ~o_busy;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - self-checking bench for alu_ctrl_stage against a behavioural model
module tb_alu_ctrl_stage;

    localparam int LAT = 4;
`ifdef ALU_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_stall = 1'b0;
    logic       i_flush = 1'b0;
    logic [2:0] i_alu_op = 3'd0;
    logic [5:0] i_inst_funcion = 6'd0;
    logic [5:0] i_opcode = 6'd0;
    logic       o_ready, o_valid, o_shift_imm, o_shift_var, o_illegal, o_busy;
    logic [3:0] o_alu_code;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] code;
        logic       imm;
        logic       vr;
        logic       ill;
    } dec_t;

    logic       m_valid = 1'b0;
    logic [3:0] m_code  = 4'd2;
    logic       m_imm   = 1'b0;
    logic       m_var   = 1'b0;
    logic       m_ill   = 1'b0;
    int         m_busy_left = 0;

    logic [3:0] logic_tab [4] = '{4'd0, 4'd1, 4'd3, 4'd4};
    logic [3:0] shift_tab [4] = '{4'd5, 4'd5, 4'd8, 4'd9};
    int         fn_pool   [20] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43,
                                   0, 2, 3, 4, 6, 7, 24, 25, 26, 27};

    alu_ctrl_stage #(
        .NB_ALU_CONTROL(4), .NB_ALU_OP(3), .NB_FUNCION(6), .NB_OPCODE(6), .MULDIV_LAT(LAT)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
        .i_flush(i_flush), .i_alu_op(i_alu_op), .i_inst_funcion(i_inst_funcion),
        .i_opcode(i_opcode), .o_ready(o_ready), .o_valid(o_valid), .o_alu_code(o_alu_code),
        .o_shift_imm(o_shift_imm), .o_shift_var(o_shift_var), .o_illegal(o_illegal),
        .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    function automatic dec_t ref_decode(input logic [2:0] op, input logic [5:0] fn, input logic [5:0] oc);
        dec_t r;
        int f;
        int o;
        r = '{code: 4'd2, imm: 1'b0, vr: 1'b0, ill: 1'b0};
        f = int'(fn);
        o = int'(oc);
        case (op)
            3'd0: r.code = 4'd2;
            3'd1: r.code = 4'd6;
            3'd4: r.code = 4'd11;
            3'd2: begin
                if (f == 32 || f == 33)          r.code = 4'd2;
                else if (f == 34 || f == 35)     r.code = 4'd6;
                else if (f >= 36 && f <= 39)     r.code = logic_tab[f - 36];
                else if (f == 42)                r.code = 4'd7;
                else if (f == 43)                r.code = 4'd10;
                else if (f == 0 || f == 2 || f == 3) begin r.code = shift_tab[f];     r.imm = 1'b1; end
                else if (f == 4 || f == 6 || f == 7) begin r.code = shift_tab[f - 4]; r.vr  = 1'b1; end
                else if (f >= 24 && f <= 27 && MD_EN) r.code = 4'd12;
                else                             r.ill  = 1'b1;
            end
            3'd3: begin
                case (o)
                    8, 9:    r.code = 4'd2;
                    10:      r.code = 4'd7;
                    11:      r.code = 4'd10;
                    12:      r.code = 4'd0;
                    13:      r.code = 4'd1;
                    14:      r.code = 4'd3;
                    15:      r.code = 4'd11;
                    default: r.ill  = 1'b1;
                endcase
            end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Apply one cycle of inputs, advance the clock, and advance the model in step.
    task automatic step(input logic rst, input logic v, input logic st, input logic fl,
                        input logic [2:0] op, input logic [5:0] fn, input logic [5:0] oc);
        dec_t d;
        logic acc;
        i_reset = rst; i_valid = v; i_stall = st; i_flush = fl;
        i_alu_op = op; i_inst_funcion = fn; i_opcode = oc;
        d   = ref_decode(op, fn, oc);
        acc = v && (m_busy_left == 0) && !st && !fl;
        @(posedge i_clock);
        #1;
        if (rst || fl) begin
            m_valid = 1'b0; m_code = 4'd2; m_imm = 1'b0; m_var = 1'b0; m_ill = 1'b0;
            m_busy_left = 0;
        end else begin
            if (m_busy_left > 0) m_busy_left--;
            if (st) begin
                m_valid = m_valid;
            end else if (acc) begin
                m_valid = 1'b1; m_code = d.code; m_imm = d.imm; m_var = d.vr; m_ill = d.ill;
                if (d.code == 4'd12) m_busy_left = LAT;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 6'b100010, 6'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_shift_imm, o_shift_var, o_illegal, o_busy, o_ready} !== 9'b0_0010_000_01) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b code=%b imm=%b var=%b ill=%b busy=%b rdy=%b want 0 0010 0 0 0 0 1",
                     o_valid, o_alu_code, o_shift_imm, o_shift_var, o_illegal, o_busy, o_ready);
        end
    endtask

    task automatic test_decode();
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b100010, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_illegal} !== 6'b1_0110_0) begin
            n_fail++; $display("FAIL sub_decode: got v=%b code=%b ill=%b want 1 0110 0", o_valid, o_alu_code, o_illegal);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 6'd0, 6'b001101);
        n_checks++;
        if ({o_valid, o_alu_code, o_shift_var} !== 6'b1_0001_0) begin
            n_fail++; $display("FAIL ori_decode: got v=%b code=%b var=%b want 1 0001 0", o_valid, o_alu_code, o_shift_var);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b000110, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_shift_imm, o_shift_var} !== 7'b1_1000_01) begin
            n_fail++; $display("FAIL srlv_decode: got v=%b code=%b imm=%b var=%b want 1 1000 0 1",
                               o_valid, o_alu_code, o_shift_imm, o_shift_var);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b000000, 6'd0);
        n_checks++;
        if ({o_alu_code, o_shift_imm, o_shift_var} !== 6'b0101_10) begin
            n_fail++; $display("FAIL sll_decode: got code=%b imm=%b var=%b want 0101 1 0", o_alu_code, o_shift_imm, o_shift_var);
        end
    endtask

    task automatic test_stall_flush();
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b100111, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code} !== 5'b1_0100) begin
            n_fail++; $display("FAIL nor_accept: got v=%b code=%b want 1 0100", o_valid, o_alu_code);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 6'b100000, 6'd0);
            n_checks++;
            if ({o_valid, o_alu_code} !== 5'b1_0100) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b code=%b want 1 0100", k, o_valid, o_alu_code);
            end
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 6'b100100, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_illegal} !== 6'b0_0010_0) begin
            n_fail++; $display("FAIL flush_bubble: got v=%b code=%b ill=%b want 0 0010 0", o_valid, o_alu_code, o_illegal);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b100101, 6'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 6'b100110, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code} !== 5'b0_0001) begin
            n_fail++; $display("FAIL idle_hold: got v=%b code=%b want 0 0001", o_valid, o_alu_code);
        end
    endtask

    task automatic test_illegal();
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b111111, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_illegal} !== 6'b1_0010_1) begin
            n_fail++; $display("FAIL bad_funct: got v=%b code=%b ill=%b want 1 0010 1", o_valid, o_alu_code, o_illegal);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 6'b100010, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_illegal} !== 6'b1_0010_1) begin
            n_fail++; $display("FAIL bad_class: got v=%b code=%b ill=%b want 1 0010 1", o_valid, o_alu_code, o_illegal);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 6'd0, 6'b000100);
        n_checks++;
        if ({o_alu_code, o_illegal} !== 5'b0010_1) begin
            n_fail++; $display("FAIL bad_opcode: got code=%b ill=%b want 0010 1", o_alu_code, o_illegal);
        end
    endtask

    task automatic test_muldiv();
`ifdef ALU_CTRL_MULDIV_EN
        int busy_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b011000, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_busy, o_ready} !== 7'b1_1100_10) begin
            n_fail++; $display("FAIL muldiv_accept: got v=%b code=%b busy=%b rdy=%b want 1 1100 1 0",
                               o_valid, o_alu_code, o_busy, o_ready);
        end
        busy_cnt = 1;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b100000, 6'd0);
            if (!o_busy) break;
            busy_cnt++;
            n_checks++;
            if ({o_valid, o_ready} !== 2'b00) begin
                n_fail++; $display("FAIL busy_ignore[%0d]: got v=%b rdy=%b want 0 0", k, o_valid, o_ready);
            end
        end
        n_checks++;
        if (busy_cnt != LAT) begin
            n_fail++; $display("FAIL busy_window: got %0d cycles want %0d", busy_cnt, LAT);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b011011, 6'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 6'd0, 6'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 6'd0, 6'd0);
        n_checks++;
        if ({o_busy, o_ready, o_valid} !== 3'b010) begin
            n_fail++; $display("FAIL flush_busy: got busy=%b rdy=%b v=%b want 0 1 0", o_busy, o_ready, o_valid);
        end
`else
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b011010, 6'd0);
        n_checks++;
        if ({o_valid, o_alu_code, o_illegal, o_busy, o_ready} !== 8'b1_0010_101) begin
            n_fail++; $display("FAIL muldiv_off: got v=%b code=%b ill=%b busy=%b rdy=%b want 1 0010 1 0 1",
                               o_valid, o_alu_code, o_illegal, o_busy, o_ready);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 6'b011000 + 6'(k), 6'd0);
            n_checks++;
            if ({o_busy, o_ready, o_illegal} !== 3'b011) begin
                n_fail++; $display("FAIL muldiv_off_busy[%0d]: got busy=%b rdy=%b ill=%b want 0 1 1", k, o_busy, o_ready, o_illegal);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic       rst, v, st, fl;
        logic [2:0] op;
        logic [5:0] fn, oc;
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) < 2);
            v   = ($urandom_range(0, 99) < 75);
            st  = ($urandom_range(0, 99) < 15);
            fl  = ($urandom_range(0, 99) < 6);
            op  = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
            fn  = ($urandom_range(0, 3) != 0) ? 6'(fn_pool[$urandom_range(0, 19)]) : 6'($urandom);
            oc  = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(8, 15)) : 6'($urandom);
            step(rst, v, st, fl, op, fn, oc);
            n_checks++;
            if ({o_valid, o_alu_code, o_shift_imm, o_shift_var, o_illegal, o_busy, o_ready} !==
                {m_valid, m_code, m_imm, m_var, m_ill, (m_busy_left > 0), (m_busy_left == 0)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b code=%b imm=%b var=%b ill=%b busy=%b rdy=%b want %b %b %b %b %b %b %b",
                         k, o_valid, o_alu_code, o_shift_imm, o_shift_var, o_illegal, o_busy, o_ready,
                         m_valid, m_code, m_imm, m_var, m_ill, (m_busy_left > 0), (m_busy_left == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stall_flush();
        test_illegal();
        test_muldiv();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
